ppu_reg_file: RTL

Parametrised CPU-facing PPU register file for 0x2000-0x2007, mirrored every 8 bytes. It implements the shared write toggle and the internal v/t/fine-x scroll/address registers. It provides a buffered PPUDATA path with a req/ack handshake to the VRAM arbiter, OAM address auto-increment, VBlank/sprite status flags and NMI generation. It sits between the CPU bus decoder and the PPU rendering, VRAM and OAM blocks.

---
 rtl/ppu_reg_file.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_reg_file.sv
// ppu_reg_file: CPU-facing PPU register file (0x2000-0x2007, mirrored every
// 8 bytes). Holds PPUCTRL/PPUMASK, the v/t/fine-x scroll state with the shared
// write toggle, the buffered PPUDATA path toward the VRAM arbiter, OAMADDR with
// auto-increment, the VBlank/sprite status flags and the NMI output.
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   cs, we, reg_sel       one-cycle register access strobe, direction, index
//   cpu_din, cpu_dout     CPU write data / registered read data
//   busy                  PPUDATA VRAM transaction pending
//   vram_req/we/addr/wdata request to the VRAM arbiter, held until ack
//   vram_ack, vram_rdata  completion pulse and read data
//   oam_addr/we/wdata     OAM address and write pulse
//   oam_rdata             OAM read data at oam_addr (combinational)
//   vblank_set, frame_clr, spr0_hit, spr_ovf   status event pulses
//   ctrl_out, mask_out, v_out, t_out, fine_x   state for rendering
//   nmi_n                 registered active-low NMI
module ppu_reg_file #(
  parameter int VADDR_W = 14,
  parameter int OAM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               we,
  input  logic [2:0]         reg_sel,
  input  logic [7:0]         cpu_din,
  output logic [7:0]         cpu_dout,
  output logic               busy,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VADDR_W-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_ack,
  input  logic [7:0]         vram_rdata,
  output logic [OAM_AW-1:0]  oam_addr,
  output logic               oam_we,
  output logic [7:0]         oam_wdata,
  input  logic [7:0]         oam_rdata,
  input  logic               vblank_set,
  input  logic               frame_clr,
  input  logic               spr0_hit,
  input  logic               spr_ovf,
  output logic [7:0]         ctrl_out,
  output logic [7:0]         mask_out,
  output logic [VADDR_W-1:0] v_out,
  output logic [VADDR_W-1:0] t_out,
  output logic [2:0]         fine_x,
  output logic               nmi_n
);

  localparam logic [VADDR_W-1:0] V_INC1  = VADDR_W'(1);
  localparam logic [VADDR_W-1:0] V_INC32 = VADDR_W'(32);
  localparam logic [OAM_AW-1:0]  OAM_INC = OAM_AW'(1);

  logic [7:0]         ctrl_r, ctrl_s, mask_r, mask_s;
  logic [7:0]         buf_r, buf_s, openbus_r, openbus_s;
  logic [7:0]         cpu_dout_r, cpu_dout_s, vram_wdata_r, vram_wdata_s;
  logic [7:0]         oam_wdata_r, oam_wdata_s;
  logic [VADDR_W-1:0] v_r, v_s, t_r, t_s, vram_addr_r, vram_addr_s;
  logic [OAM_AW-1:0]  oam_addr_r, oam_addr_s;
  logic [2:0]         fine_x_r, fine_x_s;
  logic               w_r, w_s, vblank_r, vblank_s, s0_r, s0_s, ovf_r, ovf_s;
  logic               vram_req_r, vram_req_s, vram_we_r, vram_we_s;
  logic               oam_we_r, oam_we_s, nmi_n_r, nmi_n_s;
  logic               status_rd_s;

  // Next-state decode for register accesses, VRAM completion and status flags
  always_comb begin
    ctrl_s       = ctrl_r;
    mask_s       = mask_r;
    buf_s        = buf_r;
    openbus_s    = openbus_r;
    cpu_dout_s   = cpu_dout_r;
    vram_wdata_s = vram_wdata_r;
    oam_wdata_s  = oam_wdata_r;
    v_s          = v_r;
    t_s          = t_r;
    vram_addr_s  = vram_addr_r;
    fine_x_s     = fine_x_r;
    w_s          = w_r;
    vram_req_s   = vram_req_r;
    vram_we_s    = vram_we_r;
    oam_we_s     = 1'b0;
    status_rd_s  = 1'b0;

    // Completion: capture read data and step v. A PPUADDR load below may
    // still override v on the same edge.
    if (vram_req_r && vram_ack) begin
      vram_req_s = 1'b0;
      v_s        = v_r + (ctrl_r[2] ? V_INC32 : V_INC1);
      buf_s      = vram_we_r ? buf_r : vram_rdata;
    end else begin
      vram_req_s = vram_req_r;
    end

    // OAMADDR steps after the cycle in which the OAM write pulse was visible
    oam_addr_s = oam_we_r ? (oam_addr_r + OAM_INC) : oam_addr_r;

    if (cs && we) begin
      openbus_s = cpu_din;
      case (reg_sel)
        3'd0: begin
          ctrl_s       = cpu_din;
          t_s[11:10]   = cpu_din[1:0];
        end
        3'd1: mask_s = cpu_din;
        3'd3: oam_addr_s = cpu_din[OAM_AW-1:0];
        3'd4: begin
          oam_we_s    = 1'b1;
          oam_wdata_s = cpu_din;
        end
        3'd5: begin
          if (!w_r) begin
            t_s[4:0] = cpu_din[7:3];
            fine_x_s = cpu_din[2:0];
            w_s      = 1'b1;
          end else begin
            t_s[13:12] = cpu_din[1:0];
            t_s[9:5]   = cpu_din[7:3];
            // bit 14 exists only for VADDR_W > 14; otherwise d[2] is dropped
            for (int i = 14; i < VADDR_W && i < 15; i++) t_s[i] = cpu_din[2];
            w_s = 1'b0;
          end
        end
        3'd6: begin
          if (!w_r) begin
            t_s[13:8] = cpu_din[5:0];
            for (int i = 14; i < VADDR_W; i++) t_s[i] = 1'b0;
            w_s = 1'b1;
          end else begin
            t_s[7:0] = cpu_din;
            v_s      = t_s;
            w_s      = 1'b0;
          end
        end
        3'd7: begin
          if (!vram_req_r) begin
            vram_req_s   = 1'b1;
            vram_we_s    = 1'b1;
            vram_addr_s  = v_r;
            vram_wdata_s = cpu_din;
          end else begin
            // ignored while busy: no state change at all, open bus included
            openbus_s = openbus_r;
          end
        end
        default: openbus_s = cpu_din;
      endcase
    end else if (cs && !we) begin
      case (reg_sel)
        3'd2: begin
          cpu_dout_s  = {vblank_r, s0_r, ovf_r, openbus_r[4:0]};
          openbus_s   = cpu_dout_s;
          status_rd_s = 1'b1;
          w_s         = 1'b0;
        end
        3'd4: begin
          cpu_dout_s = oam_rdata;
          openbus_s  = oam_rdata;
        end
        3'd7: begin
          if (!vram_req_r) begin
            cpu_dout_s   = buf_r;
            openbus_s    = buf_r;
            vram_req_s   = 1'b1;
            vram_we_s    = 1'b0;
            vram_addr_s  = v_r;
            vram_wdata_s = cpu_din;
          end else begin
            cpu_dout_s = cpu_dout_r;
          end
        end
        default: cpu_dout_s = openbus_r;
      endcase
    end else begin
      cpu_dout_s = cpu_dout_r;
    end

    // frame_clr dominates; a status read hides a same-cycle vblank_set
    if (frame_clr) begin
      vblank_s = 1'b0;
      s0_s     = 1'b0;
      ovf_s    = 1'b0;
    end else begin
      vblank_s = status_rd_s ? 1'b0 : (vblank_set ? 1'b1 : vblank_r);
      s0_s     = spr0_hit ? 1'b1 : s0_r;
      ovf_s    = spr_ovf ? 1'b1 : ovf_r;
    end

    nmi_n_s = ~(vblank_r & ctrl_r[7]);
  end

  // State register; reset aborts any outstanding VRAM request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r       <= 8'h00;
      mask_r       <= 8'h00;
      buf_r        <= 8'h00;
      openbus_r    <= 8'h00;
      cpu_dout_r   <= 8'h00;
      vram_wdata_r <= 8'h00;
      oam_wdata_r  <= 8'h00;
      v_r          <= '0;
      t_r          <= '0;
      vram_addr_r  <= '0;
      oam_addr_r   <= '0;
      fine_x_r     <= 3'd0;
      w_r          <= 1'b0;
      vblank_r     <= 1'b0;
      s0_r         <= 1'b0;
      ovf_r        <= 1'b0;
      vram_req_r   <= 1'b0;
      vram_we_r    <= 1'b0;
      oam_we_r     <= 1'b0;
      nmi_n_r      <= 1'b1;
    end else begin
      ctrl_r       <= ctrl_s;
      mask_r       <= mask_s;
      buf_r        <= buf_s;
      openbus_r    <= openbus_s;
      cpu_dout_r   <= cpu_dout_s;
      vram_wdata_r <= vram_wdata_s;
      oam_wdata_r  <= oam_wdata_s;
      v_r          <= v_s;
      t_r          <= t_s;
      vram_addr_r  <= vram_addr_s;
      oam_addr_r   <= oam_addr_s;
      fine_x_r     <= fine_x_s;
      w_r          <= w_s;
      vblank_r     <= vblank_s;
      s0_r         <= s0_s;
      ovf_r        <= ovf_s;
      vram_req_r   <= vram_req_s;
      vram_we_r    <= vram_we_s;
      oam_we_r     <= oam_we_s;
      nmi_n_r      <= nmi_n_s;
    end
  end

  assign cpu_dout   = cpu_dout_r;
  assign busy       = vram_req_r;
  assign vram_req   = vram_req_r;
  assign vram_we    = vram_we_r;
  assign vram_addr  = vram_addr_r;
  assign vram_wdata = vram_wdata_r;
  assign oam_addr   = oam_addr_r;
  assign oam_we     = oam_we_r;
  assign oam_wdata  = oam_wdata_r;
  assign ctrl_out   = ctrl_r;
  assign mask_out   = mask_r;
  assign v_out      = v_r;
  assign t_out      = t_r;
  assign fine_x     = fine_x_r;
  assign nmi_n      = nmi_n_r;

endmodule
